// File: rtl/uart_rx_pkt_ctrl.sv
// UART byte-stream packet framer.
// Frames are SYNC_BYTE, LEN, LEN payload bytes, CHK; the XOR of LEN, payload and CHK must be 0.
// A validated payload is buffered and then replayed over a valid/ready byte stream.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 2170
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Pkt_Data,
  output logic       o_Pkt_Valid,
  input  logic       i_Pkt_Ready,
  output logic       o_Pkt_Last,
  output logic       o_Busy,
  output logic       o_Err_Chk,
  output logic       o_Err_Len,
  output logic       o_Err_Timeout,
  output logic       o_Overrun,
  output logic [7:0] o_Pkt_Count
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MaxLen8 = 8'(MAX_LEN);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLen     = 3'd1;
  localparam logic [2:0] StPayload = 3'd2;
  localparam logic [2:0] StCheck   = 3'd3;
  localparam logic [2:0] StOutput  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;   // write index while receiving, read index in StOutput
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_tmo_q, err_tmo_d;
  logic          ovr_q, ovr_d;
  logic          buf_we;
  logic          in_frame;
  logic          at_last;
  logic [7:0]    mem_q [MAX_LEN];

  assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StCheck);
  assign at_last  = (idx_q == len_q - 8'd1);

  // Next-state, datapath and error-pulse decode.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    ovr_d     = 1'b0;
    buf_we    = 1'b0;

    // A strobe always wins over an expiring timeout, so a byte on the terminal cycle is kept.
    if (!in_frame || i_RX_DV) begin
      tmo_d = '0;
    end else if (tmo_q == TmoLast) begin
      tmo_d     = '0;
      state_d   = StIdle;
      err_tmo_d = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) state_d = StLen;
      end
      StLen: begin
        if (i_RX_DV) begin
          if ((i_RX_Byte == 8'd0) || (i_RX_Byte > MaxLen8)) begin
            err_len_d = 1'b1;
            state_d   = StIdle;
          end else begin
            len_d   = i_RX_Byte;
            chk_d   = i_RX_Byte;
            idx_d   = 8'd0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (i_RX_DV) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ i_RX_Byte;
          idx_d  = idx_q + 8'd1;
          if (at_last) state_d = StCheck;
        end
      end
      StCheck: begin
        if (i_RX_DV) begin
          if ((chk_q ^ i_RX_Byte) == 8'd0) begin
            idx_d   = 8'd0;
            cnt_d   = cnt_q + 8'd1;
            state_d = StOutput;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StOutput: begin
        // No room to hold an incoming byte while replaying; drop it and flag it.
        if (i_RX_DV) ovr_d = 1'b1;
        if (i_Pkt_Ready) begin
          if (at_last) state_d = StIdle;
          else         idx_d   = idx_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and registered error pulses.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      chk_q     <= 8'd0;
      tmo_q     <= '0;
      cnt_q     <= 8'd0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      ovr_q     <= ovr_d;
    end
  end

  // Payload buffer; contents are only meaningful after a full frame, so no reset.
  always_ff @(posedge i_Clock) begin
    if (buf_we) mem_q[idx_q[AW-1:0]] <= i_RX_Byte;
  end

  assign o_Pkt_Valid   = (state_q == StOutput);
  assign o_Pkt_Last    = o_Pkt_Valid && at_last;
  assign o_Pkt_Data    = o_Pkt_Valid ? mem_q[idx_q[AW-1:0]] : 8'd0;
  assign o_Busy        = (state_q != StIdle);
  assign o_Err_Chk     = err_chk_q;
  assign o_Err_Len     = err_len_q;
  assign o_Err_Timeout = err_tmo_q;
  assign o_Overrun     = ovr_q;
  assign o_Pkt_Count   = cnt_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: good/bad frames, length limits, timeout,
// backpressure with overrun, and asynchronous reset mid-frame.
module tb_uart_rx_pkt_ctrl;

  localparam int unsigned Tmo = 2170;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       ready = 1'b1;
  logic [7:0] pkt_data;
  logic       pkt_valid, pkt_last, busy;
  logic       err_chk, err_len, err_tmo, overrun;
  logic [7:0] pkt_count;

  int checks = 0;
  int errors = 0;
  int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0, n_beats = 0;
  int s_chk, s_len, s_tmo, s_ovr, s_beats;
  logic [7:0] pl [16];
  logic [7:0] sum;

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (16),
    .TIMEOUT_CLKS(Tmo)
  ) dut (
    .i_Clock      (clk),
    .i_Rst_L      (rst_n),
    .i_RX_DV      (dv),
    .i_RX_Byte    (rx_byte),
    .o_Pkt_Data   (pkt_data),
    .o_Pkt_Valid  (pkt_valid),
    .i_Pkt_Ready  (ready),
    .o_Pkt_Last   (pkt_last),
    .o_Busy       (busy),
    .o_Err_Chk    (err_chk),
    .o_Err_Len    (err_len),
    .o_Err_Timeout(err_tmo),
    .o_Overrun    (overrun),
    .o_Pkt_Count  (pkt_count)
  );

  always #5 clk = ~clk;

  // Pulse and beat tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (err_chk) n_chk++;
    if (err_len) n_len++;
    if (err_tmo) n_tmo++;
    if (overrun) n_ovr++;
    if (pkt_valid && ready) n_beats++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    dv = 1'b1;
    rx_byte = b;
    step();
    dv = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic last);
    check({tag, "_valid"}, 16'(pkt_valid), 16'd1);
    check({tag, "_data"}, 16'(pkt_data), 16'(d));
    check({tag, "_last"}, 16'(pkt_last), 16'(last));
    step();
  endtask

  task automatic snap();
    s_chk = n_chk; s_len = n_len; s_tmo = n_tmo; s_ovr = n_ovr; s_beats = n_beats;
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #10;
    check("rst_valid", 16'(pkt_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_data", 16'(pkt_data), 16'd0);
    check("rst_errs", 16'({err_chk, err_len, err_tmo, overrun}), 16'd0);
    check("rst_count", 16'(pkt_count), 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Good frame A5 03 11 22 33 03
    snap();
    send_byte(8'hA5);
    check("good_busy_len", 16'(busy), 16'd1);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("good_valid_early", 16'(pkt_valid), 16'd0);
    send_byte(8'h03);
    check("good_count", 16'(pkt_count), 16'd1);
    check("good_busy_out", 16'(busy), 16'd1);
    expect_beat("good_b0", 8'h11, 1'b0);
    expect_beat("good_b1", 8'h22, 1'b0);
    expect_beat("good_b2", 8'h33, 1'b1);
    check("good_done_valid", 16'(pkt_valid), 16'd0);
    check("good_done_busy", 16'(busy), 16'd0);
    check("good_no_err", 16'(n_chk + n_len + n_tmo + n_ovr - s_chk - s_len - s_tmo - s_ovr), 16'd0);
    check("good_beats", 16'(n_beats - s_beats), 16'd3);

    // Bad checksum A5 02 AA 55 00
    snap();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
    check("chk_pulse", 16'(err_chk), 16'd1);
    check("chk_valid", 16'(pkt_valid), 16'd0);
    step();
    check("chk_pulse_end", 16'(err_chk), 16'd0);
    check("chk_idle", 16'(busy), 16'd0);
    check("chk_npulse", 16'(n_chk - s_chk), 16'd1);
    check("chk_nbeats", 16'(n_beats - s_beats), 16'd0);
    check("chk_count", 16'(pkt_count), 16'd1);

    // Length errors: 0 and 17
    snap();
    send_byte(8'hA5); send_byte(8'h00);
    check("len0_pulse", 16'(err_len), 16'd1);
    send_byte(8'hA5);
    check("len0_cleared", 16'(err_len), 16'd0);
    send_byte(8'h11);
    check("len17_pulse", 16'(err_len), 16'd1);
    step();
    check("len_npulse", 16'(n_len - s_len), 16'd2);
    check("len_idle", 16'(busy), 16'd0);

    // Maximum length 16
    snap();
    sum = 8'h10;
    for (int i = 0; i < 16; i++) begin
      pl[i] = 8'(i * 17 + 3);
      sum = sum ^ pl[i];
    end
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(pl[i]);
    send_byte(sum);
    check("max_count", 16'(pkt_count), 16'd2);
    for (int i = 0; i < 16; i++) expect_beat("max_beat", pl[i], (i == 15));
    check("max_done", 16'(pkt_valid), 16'd0);
    check("max_nbeats", 16'(n_beats - s_beats), 16'd16);

    // Timeout after A5 01, then good single-byte frame
    snap();
    send_byte(8'hA5); send_byte(8'h01);
    repeat (Tmo - 1) step();
    check("tmo_not_yet", 16'(err_tmo), 16'd0);
    check("tmo_still_busy", 16'(busy), 16'd1);
    step();
    check("tmo_pulse", 16'(err_tmo), 16'd1);
    check("tmo_idle", 16'(busy), 16'd0);
    step();
    check("tmo_pulse_end", 16'(err_tmo), 16'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check("tmo_count", 16'(pkt_count), 16'd3);
    expect_beat("tmo_beat", 8'h7E, 1'b1);
    check("tmo_done", 16'(pkt_valid), 16'd0);
    check("tmo_npulse", 16'(n_tmo - s_tmo), 16'd1);

    // Byte on the timeout terminal cycle is kept
    snap();
    send_byte(8'hA5); send_byte(8'h01);
    repeat (Tmo - 1) step();
    send_byte(8'h7E);
    check("term_no_tmo", 16'(err_tmo), 16'd0);
    check("term_busy", 16'(busy), 16'd1);
    send_byte(8'h7F);
    expect_beat("term_beat", 8'h7E, 1'b1);
    check("term_count", 16'(pkt_count), 16'd4);
    check("term_ntmo", 16'(n_tmo - s_tmo), 16'd0);

    // Backpressure and overrun: A5 02 C3 3C FD
    snap();
    ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C); send_byte(8'hFD);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 16'(pkt_valid), 16'd1);
      check("bp_data", 16'(pkt_data), 16'hC3);
      check("bp_last", 16'(pkt_last), 16'd0);
      step();
    end
    send_byte(8'h55);
    check("ovr1_pulse", 16'(overrun), 16'd1);
    check("ovr1_data", 16'(pkt_data), 16'hC3);
    step();
    check("ovr1_end", 16'(overrun), 16'd0);
    send_byte(8'h66);
    check("ovr2_pulse", 16'(overrun), 16'd1);
    ready = 1'b1;
    expect_beat("bp_b0", 8'hC3, 1'b0);
    expect_beat("bp_b1", 8'h3C, 1'b1);
    check("bp_done", 16'(pkt_valid), 16'd0);
    check("bp_novr", 16'(n_ovr - s_ovr), 16'd2);
    check("bp_nbeats", 16'(n_beats - s_beats), 16'd2);
    check("bp_count", 16'(pkt_count), 16'd5);

    // Asynchronous reset mid-payload
    snap();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    check("arst_pre_busy", 16'(busy), 16'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 16'(busy), 16'd0);
    check("arst_count", 16'(pkt_count), 16'd0);
    check("arst_outs", 16'({pkt_valid, pkt_last, pkt_data}), 16'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("arst_no_err", 16'(n_chk + n_len + n_tmo + n_ovr - s_chk - s_len - s_tmo - s_ovr), 16'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    expect_beat("arst_beat", 8'h7E, 1'b1);
    check("arst_done", 16'(pkt_valid), 16'd0);
    check("arst_count_after", 16'(pkt_count), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
